burst_load: RTL and testbench
=============================

BURST_LOAD -- requirements
Module: burst_load

Interface
REQ-001 SHALL have parameters (name, default, meaning): SMC_COUNT 6 SMC slices; UR_BYTE_CNT 16 bytes per UR entry; ADDR_WIDTH 32 AXI address bits; DATA_WIDTH 128 data bits; INTLV_STEP 64 per-SMC address stride; BURST_WIDTH 8 burst-length bits; UR_ADDR_WIDTH 11; UR_ID_WIDTH 3.
REQ-002 SHALL use one clock; reset is asynchronous and active-high: clk in 1 clock; rst in 1 async active-high reset.
REQ-003 SHALL have ports ldb_u_valid in 1 command valid; ldb_u_ready out 1 command accept; ldb_u_smc_strb in SMC_COUNT SMC mask (all-zero = all enabled); ldb_u_byte_strb in 4 last-beat byte count code; ldb_u_brst in BURST_WIDTH beats per SMC; ldb_u_gr_base_addr in ADDR_WIDTH base address; ldb_u_ur_id in UR_ID_WIDTH target UR; ldb_u_ur_addr in UR_ADDR_WIDTH UR start entry.
REQ-004 SHALL have ports ur_we out 1; ur_smc_sel out clog2(SMC_COUNT) target SMC; ur_id out UR_ID_WIDTH; ur_addr out UR_ADDR_WIDTH; ur_wdata out DATA_WIDTH; ur_wstrb out UR_BYTE_CNT.
REQ-005 SHALL have ports axi_arvalid out 1; axi_araddr out ADDR_WIDTH; axi_arlen out BURST_WIDTH; axi_arready in 1; axi_rvalid in 1; axi_rdata in DATA_WIDTH; axi_rresp in 2; axi_rlast in 1; axi_rready out 1; ldb_d_valid out 1; ldb_d_done out 1; ldb_d_err out 1.

Function
REQ-006 SHALL implement states IDLE, SCAN, ARREQ, RDATA, DONE.
REQ-007 SHALL drive ldb_u_ready=1 only in IDLE; ldb_u_valid&ldb_u_ready latches all command fields and moves to SCAN with smc index 0 and error flag cleared.
REQ-008 SCAN SHALL advance the smc index past disabled SMCs, one index per cycle; enabled index -> ARREQ; index past SMC_COUNT-1 -> DONE.
REQ-009 When latched brst==0, SCAN SHALL go directly to DONE with no AXI or UR traffic.
REQ-010 ARREQ SHALL hold axi_arvalid=1, axi_araddr=base+smc*INTLV_STEP (modulo 2^ADDR_WIDTH), axi_arlen=brst-1, stable until axi_arready; on handshake clear arvalid, reset beat counter to 0, enter RDATA.
REQ-011 RDATA SHALL hold axi_rready=1; each rvalid&rready beat increments the beat counter.
REQ-012 For each accepted beat k, the cycle after SHALL pulse ur_we=1 for one cycle with ur_wdata=rdata, ur_smc_sel=smc, ur_id=latched id, ur_addr=ur_addr_start+k (wraps modulo 2^UR_ADDR_WIDTH).
REQ-013 ur_wstrb SHALL be all ones except for beat k==brst-1, which uses the code: 0 -> all 16 bytes; n=1..15 -> low n bytes set.
REQ-014 On beat k==brst-1, RDATA SHALL drop rready the next cycle, increment smc index, return to SCAN.
REQ-015 Error flag SHALL be set (sticky until next command) when any beat has rresp!=0, or rlast disagrees with k==brst-1; termination is by beat count only, rlast never ends a burst early.
REQ-016 DONE SHALL pulse ldb_d_valid=ldb_d_done=1 for exactly one cycle, ldb_d_err=error flag in that cycle (0 otherwise), then IDLE.
REQ-017 ldb_u_valid outside IDLE SHALL be ignored; command fields SHALL not change mid-operation.
REQ-018 rvalid outside RDATA SHALL be ignored (rready=0 there).

Reset
REQ-019 rst SHALL asynchronously force IDLE and all outputs to 0 (ldb_u_ready becomes 1 at the first clock after release), including mid-burst; no UR write or done pulse SHALL follow an interrupted command.
REQ-020 All latched fields, counters and the error flag SHALL reset to 0.

Verification
REQ-021 base 0x1000, smc_strb 0, brst 4, byte_strb 0, ur_addr 0x10 -> 6 AR at 0x1000,0x1040..0x1140, arlen 3; 24 ur_we, ur_addr 0x10..0x13 per SMC, all wstrb 0xFFFF; one done, err 0.
REQ-022 smc_strb 6'b100010, brst 2, byte_strb 5 -> AR only at base+0x40 and base+0x140; last beat wstrb 0x001F, first 0xFFFF; ur_smc_sel 1 then 5.
REQ-023 arready held low 10 cycles, rvalid toggling every other cycle -> araddr/arlen stable while waiting; exactly brst UR writes in order, data matching rdata.
REQ-024 rresp=2'b10 on one beat of SMC 2 -> all beats still written; done with ldb_d_err=1; next clean command reports err 0.
REQ-025 brst 0 -> no arvalid, no ur_we, done pulse within SMC_COUNT+2 cycles; ur_addr 0x7FE, brst 4 -> ur_addr 0x7FE,0x7FF,0x000,0x001.
REQ-026 rst asserted mid-RDATA -> outputs 0 immediately; no done pulse; a new command afterwards completes normally.

Source files
------------

// File: rtl/burst_load.sv
// Burst loader: for each enabled SMC slice, issue one AXI read burst at an
// interleaved address and stream the returned beats into the UR write port.
module burst_load #(
  parameter int SMC_COUNT     = 6,
  parameter int UR_BYTE_CNT   = 16,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 128,
  parameter int INTLV_STEP    = 64,
  parameter int BURST_WIDTH   = 8,
  parameter int UR_ADDR_WIDTH = 11,
  parameter int UR_ID_WIDTH   = 3,
  localparam int SEL_W        = (SMC_COUNT > 1) ? $clog2(SMC_COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ldb_u_valid,
  output logic                     ldb_u_ready,
  input  logic [SMC_COUNT-1:0]     ldb_u_smc_strb,
  input  logic [3:0]               ldb_u_byte_strb,
  input  logic [BURST_WIDTH-1:0]   ldb_u_brst,
  input  logic [ADDR_WIDTH-1:0]    ldb_u_gr_base_addr,
  input  logic [UR_ID_WIDTH-1:0]   ldb_u_ur_id,
  input  logic [UR_ADDR_WIDTH-1:0] ldb_u_ur_addr,
  output logic                     ur_we,
  output logic [SEL_W-1:0]         ur_smc_sel,
  output logic [UR_ID_WIDTH-1:0]   ur_id,
  output logic [UR_ADDR_WIDTH-1:0] ur_addr,
  output logic [DATA_WIDTH-1:0]    ur_wdata,
  output logic [UR_BYTE_CNT-1:0]   ur_wstrb,
  output logic                     axi_arvalid,
  output logic [ADDR_WIDTH-1:0]    axi_araddr,
  output logic [BURST_WIDTH-1:0]   axi_arlen,
  input  logic                     axi_arready,
  input  logic                     axi_rvalid,
  input  logic [DATA_WIDTH-1:0]    axi_rdata,
  input  logic [1:0]               axi_rresp,
  input  logic                     axi_rlast,
  output logic                     axi_rready,
  output logic                     ldb_d_valid,
  output logic                     ldb_d_done,
  output logic                     ldb_d_err
);
  localparam int IDX_W = $clog2(SMC_COUNT + 1);

  typedef enum logic [2:0] {IDLE, SCAN, ARREQ, RDATA, DONE} state_t;
  state_t state_q, state_d;

  logic [SMC_COUNT-1:0]     smc_strb_q, smc_strb_d;
  logic [3:0]               byte_strb_q, byte_strb_d;
  logic [BURST_WIDTH-1:0]   brst_q, brst_d;
  logic [ADDR_WIDTH-1:0]    base_q, base_d;
  logic [UR_ID_WIDTH-1:0]   id_q, id_d;
  logic [UR_ADDR_WIDTH-1:0] uaddr_q, uaddr_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [BURST_WIDTH-1:0]   beat_q, beat_d;
  logic                     err_q, err_d;
  logic                     ready_q, ready_d;
  logic                     ur_we_q, ur_we_d;
  logic [SEL_W-1:0]         ur_sel_q, ur_sel_d;
  logic [UR_ID_WIDTH-1:0]   ur_id_q, ur_id_d;
  logic [UR_ADDR_WIDTH-1:0] ur_addr_q, ur_addr_d;
  logic [DATA_WIDTH-1:0]    ur_wdata_q, ur_wdata_d;
  logic [UR_BYTE_CNT-1:0]   ur_wstrb_q, ur_wstrb_d;

  logic                   accept, smc_en, scan_end, last_beat, beat_fire;
  logic [UR_BYTE_CNT-1:0] last_strb;

  assign accept    = ldb_u_valid & ready_q;
  assign scan_end  = (brst_q == '0) || (idx_q >= IDX_W'(SMC_COUNT));
  assign last_beat = (beat_q == brst_q - BURST_WIDTH'(1));
  assign beat_fire = axi_rvalid & axi_rready;

  // An all-zero mask means every slice is enabled.
  always_comb begin
    smc_en = (smc_strb_q == '0);
    for (int i = 0; i < SMC_COUNT; i++)
      if (idx_q == IDX_W'(i) && smc_strb_q[i]) smc_en = 1'b1;
    for (int i = 0; i < UR_BYTE_CNT; i++)
      last_strb[i] = (byte_strb_q == 4'd0) || (i < int'(byte_strb_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (scan_end) state_d = DONE;
               else if (smc_en) state_d = ARREQ;
      ARREQ:   if (axi_arready) state_d = RDATA;
      RDATA:   if (beat_fire && last_beat) state_d = SCAN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    smc_strb_d  = smc_strb_q;
    byte_strb_d = byte_strb_q;
    brst_d      = brst_q;
    base_d      = base_q;
    id_d        = id_q;
    uaddr_d     = uaddr_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    err_d       = err_q;
    ready_d     = (state_d == IDLE);
    ur_we_d     = 1'b0;
    ur_sel_d    = ur_sel_q;
    ur_id_d     = ur_id_q;
    ur_addr_d   = ur_addr_q;
    ur_wdata_d  = ur_wdata_q;
    ur_wstrb_d  = ur_wstrb_q;
    case (state_q)
      IDLE: if (accept) begin
        smc_strb_d  = ldb_u_smc_strb;
        byte_strb_d = ldb_u_byte_strb;
        brst_d      = ldb_u_brst;
        base_d      = ldb_u_gr_base_addr;
        id_d        = ldb_u_ur_id;
        uaddr_d     = ldb_u_ur_addr;
        idx_d       = '0;
        beat_d      = '0;
        err_d       = 1'b0;
      end
      SCAN:  if (!scan_end && !smc_en) idx_d = idx_q + IDX_W'(1);
      ARREQ: if (axi_arready) beat_d = '0;
      RDATA: if (beat_fire) begin
        beat_d     = beat_q + BURST_WIDTH'(1);
        // rlast is only cross-checked; the beat count alone ends the burst.
        err_d      = err_q | (axi_rresp != 2'b00) | (axi_rlast != last_beat);
        ur_we_d    = 1'b1;
        ur_sel_d   = SEL_W'(idx_q);
        ur_id_d    = id_q;
        ur_addr_d  = uaddr_q + UR_ADDR_WIDTH'(beat_q);
        ur_wdata_d = axi_rdata;
        ur_wstrb_d = last_beat ? last_strb : '1;
        if (last_beat) idx_d = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smc_strb_q  <= '0;
      byte_strb_q <= '0;
      brst_q      <= '0;
      base_q      <= '0;
      id_q        <= '0;
      uaddr_q     <= '0;
      idx_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      ur_we_q     <= 1'b0;
      ur_sel_q    <= '0;
      ur_id_q     <= '0;
      ur_addr_q   <= '0;
      ur_wdata_q  <= '0;
      ur_wstrb_q  <= '0;
    end else begin
      smc_strb_q  <= smc_strb_d;
      byte_strb_q <= byte_strb_d;
      brst_q      <= brst_d;
      base_q      <= base_d;
      id_q        <= id_d;
      uaddr_q     <= uaddr_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      ur_we_q     <= ur_we_d;
      ur_sel_q    <= ur_sel_d;
      ur_id_q     <= ur_id_d;
      ur_addr_q   <= ur_addr_d;
      ur_wdata_q  <= ur_wdata_d;
      ur_wstrb_q  <= ur_wstrb_d;
    end
  end

  // Address channel is zeroed outside ARREQ so reset leaves every output at 0.
  always_comb begin
    ldb_u_ready = ready_q;
    axi_arvalid = (state_q == ARREQ);
    axi_araddr  = '0;
    axi_arlen   = '0;
    if (axi_arvalid) begin
      axi_araddr = base_q + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(INTLV_STEP);
      axi_arlen  = brst_q - BURST_WIDTH'(1);
    end
    axi_rready  = (state_q == RDATA);
    ldb_d_valid = (state_q == DONE);
    ldb_d_done  = (state_q == DONE);
    ldb_d_err   = (state_q == DONE) & err_q;
    ur_we       = ur_we_q;
    ur_smc_sel  = ur_sel_q;
    ur_id       = ur_id_q;
    ur_addr     = ur_addr_q;
    ur_wdata    = ur_wdata_q;
    ur_wstrb    = ur_wstrb_q;
  end
endmodule

// File: tb/tb_burst_load.sv
// Directed bench for burst_load: table of commands plus reset/handshake corners,
// with a behavioural AXI read slave and an independent expected-write model.
module tb_burst_load;
  logic         clk = 1'b0;
  logic         rst;
  logic         ldb_u_valid;
  logic         ldb_u_ready;
  logic [5:0]   ldb_u_smc_strb;
  logic [3:0]   ldb_u_byte_strb;
  logic [7:0]   ldb_u_brst;
  logic [31:0]  ldb_u_gr_base_addr;
  logic [2:0]   ldb_u_ur_id;
  logic [10:0]  ldb_u_ur_addr;
  logic         ur_we;
  logic [2:0]   ur_smc_sel;
  logic [2:0]   ur_id;
  logic [10:0]  ur_addr;
  logic [127:0] ur_wdata;
  logic [15:0]  ur_wstrb;
  logic         axi_arvalid;
  logic [31:0]  axi_araddr;
  logic [7:0]   axi_arlen;
  logic         axi_arready;
  logic         axi_rvalid;
  logic [127:0] axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rlast;
  logic         axi_rready;
  logic         ldb_d_valid;
  logic         ldb_d_done;
  logic         ldb_d_err;

  always #5 clk = ~clk;

  burst_load dut (
    .clk(clk), .rst(rst),
    .ldb_u_valid(ldb_u_valid), .ldb_u_ready(ldb_u_ready),
    .ldb_u_smc_strb(ldb_u_smc_strb), .ldb_u_byte_strb(ldb_u_byte_strb),
    .ldb_u_brst(ldb_u_brst), .ldb_u_gr_base_addr(ldb_u_gr_base_addr),
    .ldb_u_ur_id(ldb_u_ur_id), .ldb_u_ur_addr(ldb_u_ur_addr),
    .ur_we(ur_we), .ur_smc_sel(ur_smc_sel), .ur_id(ur_id), .ur_addr(ur_addr),
    .ur_wdata(ur_wdata), .ur_wstrb(ur_wstrb),
    .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arready(axi_arready), .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rready(axi_rready),
    .ldb_d_valid(ldb_d_valid), .ldb_d_done(ldb_d_done), .ldb_d_err(ldb_d_err)
  );

  typedef struct {
    logic [5:0]  strb;
    logic [3:0]  bstrb;
    logic [7:0]  brst;
    logic [31:0] base;
    logic [2:0]  id;
    logic [10:0] ua;
    int          dly;
    bit          tog;
    int          err_burst;
    bit          bad_last;
    int          exp_ar;
    int          exp_ur;
    bit          exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // slave controls
  int ar_dly = 0;
  bit tog = 1'b0;
  int err_burst = -1;
  bit bad_last = 1'b0;
  int burst_cnt = 0;

  logic [39:0]  ar_q[$];
  logic [160:0] ur_q[$];
  int           done_cnt = 0;
  logic [2:0]   last_d = '0;

  task automatic chk(input string n, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask

  function automatic logic [127:0] beat_data(input logic [31:0] a, input int k);
    return {a, 32'hC0DE0000 ^ 32'(k), ~a, 32'h5A5A5A5A};
  endfunction

  // Monitor: sample just after the falling edge, well clear of the active edge.
  initial forever begin
    @(negedge clk); #2;
    if (!rst) begin
      if (axi_arvalid && axi_arready) ar_q.push_back({axi_arlen, axi_araddr});
      if (ur_we) ur_q.push_back({ur_smc_sel, ur_id, ur_addr, ur_wdata, ur_wstrb});
      if (ldb_d_valid || ldb_d_done) begin
        done_cnt++;
        last_d = {ldb_d_valid, ldb_d_done, ldb_d_err};
      end
    end
  end

  task automatic slave_burst(input logic [31:0] a, input int len);
    int k = 0;
    int cyc = 0;
    while (k < len && !rst && cyc < 1000) begin
      if (tog && cyc[0]) axi_rvalid = 1'b0;
      else begin
        axi_rvalid = 1'b1;
        axi_rdata  = beat_data(a, k);
        axi_rresp  = (burst_cnt == err_burst && k == 1) ? 2'b10 : 2'b00;
        axi_rlast  = (k == len - 1) && !bad_last;
      end
      cyc++;
      if (axi_rvalid && axi_rready) k++;
      @(negedge clk);
    end
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    axi_rresp  = 2'b00;
  endtask

  // AXI read slave; drives junk rvalid while arready is held off.
  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rdata   = '0;
    axi_rresp   = 2'b00;
    axi_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && axi_arvalid) begin
        a = axi_araddr;
        l = axi_arlen;
        for (int d = 0; d < ar_dly; d++) begin
          axi_rvalid = 1'b1;
          axi_rdata  = '1;
          axi_rlast  = 1'b1;
          @(negedge clk);
          if (rst) break;
          chk("ar_stable", {axi_arvalid, axi_arlen, axi_araddr}, {1'b1, l, a});
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        if (!rst) begin
          axi_arready = 1'b1;
          @(negedge clk);
          axi_arready = 1'b0;
          slave_burst(a, int'(l) + 1);
        end
        burst_cnt++;
      end
    end
  end

  task automatic issue(input vec_t v);
    int g = 0;
    ar_dly = v.dly; tog = v.tog; err_burst = v.err_burst; bad_last = v.bad_last;
    burst_cnt = 0;
    ar_q.delete(); ur_q.delete(); done_cnt = 0; last_d = '0;
    @(negedge clk);
    while (!ldb_u_ready && g < 100) begin @(negedge clk); g++; end
    chk("cmd_ready", ldb_u_ready, 1);
    ldb_u_valid = 1'b1;
    ldb_u_smc_strb = v.strb; ldb_u_byte_strb = v.bstrb; ldb_u_brst = v.brst;
    ldb_u_gr_base_addr = v.base; ldb_u_ur_id = v.id; ldb_u_ur_addr = v.ua;
    @(negedge clk);
    ldb_u_valid = 1'b0;
    // fields must not matter once the command is taken
    ldb_u_smc_strb = 6'($urandom); ldb_u_byte_strb = 4'($urandom);
    ldb_u_brst = 8'($urandom); ldb_u_gr_base_addr = $urandom;
    ldb_u_ur_id = 3'($urandom); ldb_u_ur_addr = 11'($urandom);
  endtask

  task automatic run_vec(input string n, input vec_t v);
    logic [39:0]  e_ar[$];
    logic [160:0] e_ur[$];
    logic [31:0]  a;
    logic [15:0]  ws;
    int lat = 0;
    issue(v);
    while (done_cnt == 0 && lat < 3000) begin @(negedge clk); #3; lat++; end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 6; s++) begin
      if (v.brst != 0 && (v.strb == 6'd0 || v.strb[s])) begin
        a = v.base + 32'(s * 64);
        e_ar.push_back({v.brst - 8'd1, a});
        for (int k = 0; k < int'(v.brst); k++) begin
          ws = (k == int'(v.brst) - 1 && v.bstrb != 4'd0) ? (16'h1 << v.bstrb) - 16'h1 : 16'hFFFF;
          e_ur.push_back({3'(s), v.id, v.ua + 11'(k), beat_data(a, k), ws});
        end
      end
    end
    chk({n, "_ar_cnt"}, ar_q.size(), v.exp_ar);
    chk({n, "_ur_cnt"}, ur_q.size(), v.exp_ur);
    for (int i = 0; i < e_ar.size() && i < ar_q.size(); i++) chk({n, "_ar"}, ar_q[i], e_ar[i]);
    for (int i = 0; i < e_ur.size() && i < ur_q.size(); i++) chk({n, "_ur"}, ur_q[i], e_ur[i]);
    chk({n, "_done_cnt"}, done_cnt, 1);
    chk({n, "_done"}, last_d, {2'b11, v.exp_err});
    if (v.brst == 8'd0) chk({n, "_lat"}, lat <= 8, 1);
  endtask

  vec_t vecs[9];

  initial begin
    vec_t rv;
    int g;
    //            strb       bs  brst  base          id  ua      dly tog eb  bl  ar ur err
    vecs[0] = '{6'b000000, 0, 4, 32'h0000_1000, 3, 11'h010, 0,  0, -1, 0, 6, 24, 0};
    vecs[1] = '{6'b100010, 5, 2, 32'h0000_2000, 1, 11'h100, 0,  0, -1, 0, 2, 4,  0};
    vecs[2] = '{6'b000001, 0, 3, 32'h0000_3000, 2, 11'h020, 10, 1, -1, 0, 1, 3,  0};
    vecs[3] = '{6'b000000, 0, 2, 32'h0000_4000, 4, 11'h040, 0,  0, 2,  0, 6, 12, 1};
    vecs[4] = '{6'b001000, 15, 1, 32'h0000_5000, 5, 11'h050, 0, 0, -1, 0, 1, 1,  0};
    vecs[5] = '{6'b000000, 0, 0, 32'h0000_6000, 6, 11'h060, 0,  0, -1, 0, 0, 0,  0};
    vecs[6] = '{6'b000100, 0, 4, 32'h0000_7000, 7, 11'h7FE, 0,  0, -1, 0, 1, 4,  0};
    vecs[7] = '{6'b000011, 3, 1, 32'hFFFF_FFC0, 0, 11'h000, 0,  0, -1, 0, 2, 2,  0};
    vecs[8] = '{6'b000001, 0, 2, 32'h0000_8000, 1, 11'h080, 0,  0, -1, 1, 1, 2,  1};

    rst = 1'b1; ldb_u_valid = 1'b0;
    ldb_u_smc_strb = '0; ldb_u_byte_strb = '0; ldb_u_brst = '0;
    ldb_u_gr_base_addr = '0; ldb_u_ur_id = '0; ldb_u_ur_addr = '0;
    #1;
    chk("rst_outputs", {ldb_u_ready, ur_we, ur_smc_sel, ur_id, ur_addr, ur_wdata, ur_wstrb,
                        axi_arvalid, axi_araddr, axi_arlen, axi_rready,
                        ldb_d_valid, ldb_d_done, ldb_d_err}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_release", ldb_u_ready, 0);
    @(posedge clk); #1;
    chk("ready_first_clk", ldb_u_ready, 1);

    for (int i = 0; i < 9; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // reset in the middle of a burst
    rv = vecs[0];
    issue(rv);
    g = 0;
    while (ur_q.size() < 6 && g < 500) begin @(negedge clk); g++; end
    chk("mid_reached", ur_q.size() >= 6, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", {ldb_u_ready, ur_we, ur_wstrb, axi_arvalid, axi_araddr, axi_rready,
                            ldb_d_valid, ldb_d_done, ldb_d_err}, '0);
    ur_q.delete(); ar_q.delete(); done_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_no_ur", ur_q.size(), 0);
    chk("mid_no_done", done_cnt, 0);
    run_vec("after_rst", vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
